mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported 32-bit pipeline memory between the instruction-fetch port (IF, read-only)
//  and the data port (DM, LW/SW from the MEM stage). One transaction is in flight at a time.
//  DM has priority; a streak counter guarantees IF forward progress. if_flush drops a stale fetch
//  after a taken branch. Sits between the pipeline stages and the memory array.
// PARAMETERS
//  AW          10  memory word-address width (1024 words)
//  MEM_LAT     1   memory read latency in cycles, from the clock edge that samples mem_en to valid mem_rdata (>=1)
//  MAX_DSTREAK 2   max consecutive DM grants while IF is waiting (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  if_req     in   1   IF read request; hold until if_gnt
//  if_addr    in   AW  IF word address
//  if_flush   in   1   discard any in-flight IF response
//  if_gnt     out  1   1-cycle grant pulse for IF
//  if_rvalid  out  1   1-cycle IF read-data-valid pulse
//  if_rdata   out  32  IF read data, held until next IF response
//  dm_req     in   1   DM request; hold until dm_gnt
//  dm_we      in   1   1 = store, 0 = load
//  dm_addr    in   AW  DM word address
//  dm_wdata   in   32  store data
//  dm_gnt     out  1   1-cycle grant pulse for DM
//  dm_rvalid  out  1   1-cycle load-data-valid pulse
//  dm_wdone   out  1   1-cycle store-complete pulse
//  dm_rdata   out  32  load data, held until next DM load response
//  mem_en     out  1   memory access strobe (1 cycle per transaction)
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_addr   out  AW  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; streak=0; all outputs 0, including rdata regs; in-flight transaction abandoned.
//  All outputs are registered.
//  FSM: IDLE -> ACCESS -> WAIT -> DONE.
//   - Arbitration is evaluated at the edge that leaves IDLE or DONE. With no request, the FSM goes to (or stays in) IDLE.
//   - Grant edge t: state=ACCESS; gnt of the winner=1; mem_en=1; mem_addr/mem_we/mem_wdata latched from the winner.
//     Owner is recorded. The requester may change addr/data after seeing gnt.
//   - Edge t+1: gnt=0, mem_en=0, mem_we=0; mem_addr/mem_wdata hold; state=WAIT, cnt=1.
//   - WAIT: cnt increments each edge. At the edge where cnt==MEM_LAT: capture mem_rdata into the owner's rdata
//     (loads only); state=DONE.
//   - DONE (lasts one cycle, t+MEM_LAT+1): owner IF -> if_rvalid=1; DM load -> dm_rvalid=1; DM store -> dm_wdone=1.
//  Back-to-back grant period = MEM_LAT+2 cycles.
//  Priority: DM wins unless (if_req && streak==MAX_DSTREAK). Then IF wins and streak:=0.
//   - DM grant with if_req=1: streak+1 (saturating).
//   - DM grant with if_req=0, or any IF grant: streak:=0.
//  A request dropped before its grant is withdrawn; nothing is issued for it.
//  if_flush=1 on any cycle while owner=IF and state in {ACCESS,WAIT,DONE}:
//   - suppresses if_rvalid for that transaction (if DONE, same-cycle suppression via registered kill flag set earlier;
//     flush during DONE itself has no effect).
//   - if_rdata is not updated.
//   - The memory cycle still completes with normal timing.
//  if_flush has no effect on DM transactions or while IDLE.
//  Simultaneous rvalid/wdone and a new grant in the DONE cycle is legal.
//  A store's data is visible to any later-granted read.
//  X/undefined addr on an ungranted port is ignored.
// TESTING
//  1 MEM_LAT=1, mem[5]=32'hDEADBEEF, if_req=1 addr 5 at edge 0:
//    -> if_gnt & mem_en (addr 5) in cycle 1; if_rvalid=1, if_rdata=32'hDEADBEEF in cycle 3.
//  2 if_req & dm_req (load addr 7) together:
//    -> dm_gnt first; if_gnt exactly 3 cycles later (MEM_LAT=1); busy high throughout.
//  3 MAX_DSTREAK=2, dm_req & if_req held high:
//    -> grant order DM,DM,IF,DM,DM,IF; streak returns to 0 after each IF grant.
//  4 DM store addr 10 data 32'h00001234:
//    -> mem_en & mem_we 1 cycle, dm_wdone pulse, no dm_rvalid; following DM load of addr 10 returns 32'h00001234.
//  5 IF fetch in flight, if_flush=1 during WAIT:
//    -> no if_rvalid, if_rdata unchanged; next IF request serviced normally.
//  6 rst_n=0 during WAIT:
//    -> all outputs 0 immediately; after release no rvalid/wdone pulse; next request granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data (DM).
// One transaction in flight; DM has priority, bounded by a streak counter so IF always progresses.
module mem_port_arbiter #(
  parameter int AW          = 10,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic          dm_wdone,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            owner_if_q, owner_if_d;
  logic            own_we_q, own_we_d;
  logic            kill_q, kill_d;
  logic            if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic            if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic            dm_wdone_q, dm_wdone_d;
  logic [31:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;
  logic            if_wins;

  // Handshake: a requester holds req (and its addr/data) until it sees its 1-cycle gnt pulse;
  // dropping req before the grant edge withdraws it. Responses are 1-cycle pulses, rdata is held.
  assign if_wins = if_req && (!dm_req || (streak_q == SW'(MAX_DSTREAK)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_if_d  = owner_if_q;
    own_we_d    = own_we_q;
    kill_d      = kill_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    dm_wdone_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = CW'(1);
        if (owner_if_q && if_flush) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (owner_if_q && if_flush) kill_d = 1'b1;
        if (cnt_q == CW'(MEM_LAT)) begin
          state_d = S_DONE;
          if (owner_if_q) begin
            // A flush in this last WAIT cycle must still suppress the response.
            if (!kill_q && !if_flush) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata;
            end
          end else if (own_we_q) begin
            dm_wdone_d = 1'b1;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (if_wins) begin
          state_d    = S_ACCESS;
          owner_if_d = 1'b1;
          own_we_d   = 1'b0;
          kill_d     = 1'b0;
          streak_d   = '0;
          if_gnt_d   = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
        end else if (dm_req) begin
          state_d     = S_ACCESS;
          owner_if_d  = 1'b0;
          own_we_d    = dm_we;
          kill_d      = 1'b0;
          dm_gnt_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) streak_d = '0;
          else if (streak_q != SW'(MAX_DSTREAK)) streak_d = streak_q + SW'(1);
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      owner_if_q  <= 1'b0;
      own_we_q    <= 1'b0;
      kill_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_wdone_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_if_q  <= owner_if_d;
      own_we_q    <= own_we_d;
      kill_q      <= kill_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_wdone_q  <= dm_wdone_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt      = if_gnt_q;
  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_gnt      = dm_gnt_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign dm_wdone    = dm_wdone_q;
  assign dm_rdata    = dm_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW          = 10;
  localparam int MEM_LAT     = 1;
  localparam int MAX_DSTREAK = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid, dm_wdone;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .MAX_DSTREAK(MAX_DSTREAK)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_wdone(dm_wdone), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state_o(dbg_state)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // ---------------- memory array attached to the DUT ----------------
  logic [31:0] phys_mem [1024];
  logic [31:0] rd_pipe  [MEM_LAT];
  initial begin
    for (int i = 0; i < 1024; i++) phys_mem[i] <= init_word(i);
    for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] <= '0;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) phys_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) rd_pipe[0] <= phys_mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0]   ref_mem [1024];
  logic [31:0]   exp_q [$];
  bit            m_act, m_own_if, m_we, m_kill;
  int            m_age, m_streak;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          e_if_gnt, e_if_rvalid, e_dm_gnt, e_dm_rvalid, e_dm_wdone;
  logic          e_mem_en, e_mem_we, e_busy;
  logic [31:0]   e_if_rdata, e_dm_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 0; m_streak = 0; m_kill = 0; m_age = 0;
        exp_q.delete();
        e_if_gnt = 0; e_if_rvalid = 0; e_dm_gnt = 0; e_dm_rvalid = 0; e_dm_wdone = 0;
        e_mem_en = 0; e_mem_we = 0; e_busy = 0;
        e_if_rdata = '0; e_dm_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
      end else begin
        e_if_gnt = 0; e_if_rvalid = 0; e_dm_gnt = 0; e_dm_rvalid = 0; e_dm_wdone = 0;
        e_mem_en = 0; e_mem_we = 0;
        if (m_act) begin
          m_age++;
          if (m_own_if && if_flush && m_age <= MEM_LAT + 1) m_kill = 1;
          if (m_age == 1) begin
            if (!m_own_if && m_we) ref_mem[m_addr] = m_wdata;
            else exp_q.push_back(ref_mem[m_addr]);
          end
          if (m_age == MEM_LAT + 1) begin
            if (!m_own_if && m_we) e_dm_wdone = 1;
            else if (exp_q.size() > 0) begin
              logic [31:0] v;
              v = exp_q.pop_front();
              if (!m_own_if) begin
                e_dm_rvalid = 1;
                e_dm_rdata  = v;
              end else if (!m_kill) begin
                e_if_rvalid = 1;
                e_if_rdata  = v;
              end
            end
          end
          if (m_age == MEM_LAT + 2) m_act = 0;
        end
        if (!m_act) begin
          if (if_req && (!dm_req || m_streak == MAX_DSTREAK)) begin
            m_act = 1; m_age = 0; m_kill = 0; m_own_if = 1; m_we = 0; m_addr = if_addr;
            m_streak = 0;
            e_if_gnt = 1; e_mem_en = 1; e_mem_addr = if_addr;
          end else if (dm_req) begin
            m_act = 1; m_age = 0; m_kill = 0; m_own_if = 0; m_we = dm_we; m_addr = dm_addr;
            m_wdata = dm_wdata;
            m_streak = if_req ? ((m_streak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : m_streak + 1) : 0;
            e_dm_gnt = 1; e_mem_en = 1; e_mem_we = dm_we; e_mem_addr = dm_addr;
            e_mem_wdata = dm_wdata;
          end
        end
        e_busy = m_act;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("if_gnt", if_gnt, e_if_gnt);
      chk("if_rvalid", if_rvalid, e_if_rvalid);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_gnt", dm_gnt, e_dm_gnt);
      chk("dm_rvalid", dm_rvalid, e_dm_rvalid);
      chk("dm_wdone", dm_wdone, e_dm_wdone);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      chk("mem_en", mem_en, e_mem_en);
      chk("mem_we", mem_we, e_mem_we);
      chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
      chk("busy", busy, e_busy);
      if (e_mem_en && e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic random_cycle();
    if (if_req && if_gnt) if_req = 0;
    if (if_req && $urandom_range(0, 19) == 0) if_req = 0;
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req  = 1;
      if_addr = AW'($urandom_range(0, 15));
    end
    if (dm_req && dm_gnt) dm_req = 0;
    if (dm_req && $urandom_range(0, 19) == 0) dm_req = 0;
    if (!dm_req && $urandom_range(0, 1) == 0) begin
      dm_req   = 1;
      dm_we    = ($urandom_range(0, 2) == 0);
      dm_addr  = AW'($urandom_range(0, 15));
      dm_wdata = $urandom;
    end
    if_flush = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int k;
    bit ok;
    bit seq [6];
    bit exp_seq [6];
    exp_seq = '{1, 1, 0, 1, 1, 0};

    rst_n = 0;
    idle_inputs();
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    rst_n = 1;
    step();

    // IF fetch of address 5
    if_req = 1; if_addr = 10'd5;
    step();
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", 32'(mem_addr), 5);
    if_req = 0;
    step(); step();
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    step();

    // DM store then load of address 10
    dm_req = 1; dm_we = 1; dm_addr = 10'd10; dm_wdata = 32'h00001234;
    step();
    chk("t4_dm_gnt", dm_gnt, 1);
    chk("t4_mem_we", mem_we, 1);
    dm_req = 0;
    step();
    chk("t4_mem_en_one_cycle", mem_en, 0);
    step();
    chk("t4_dm_wdone", dm_wdone, 1);
    chk("t4_no_rvalid", dm_rvalid, 0);
    dm_req = 1; dm_we = 0; dm_addr = 10'd10;
    step();
    chk("t4_load_gnt", dm_gnt, 1);
    dm_req = 0;
    step(); step();
    chk("t4_dm_rvalid", dm_rvalid, 1);
    chk("t4_dm_rdata", dm_rdata, 32'h00001234);
    step();

    // simultaneous requests: DM first, IF three cycles later
    if_req = 1; if_addr = 10'd5; dm_req = 1; dm_we = 0; dm_addr = 10'd7;
    step();
    chk("t2_dm_first", dm_gnt, 1);
    chk("t2_if_not_first", if_gnt, 0);
    dm_req = 0;
    n = 0; ok = 1;
    do begin
      step();
      n++;
      if (!busy) ok = 0;
    end while (!if_gnt && n < 10);
    chk("t2_if_gnt_delay", 32'(n), 3);
    chk("t2_busy_held", 32'(ok), 1);
    if_req = 0;
    repeat (3) step();

    // streak: both held high
    if_req = 1; if_addr = 10'd5; dm_req = 1; dm_we = 0; dm_addr = 10'd7;
    k = 0; n = 0;
    while (k < 6 && n < 40) begin
      step();
      n++;
      if (dm_gnt) begin seq[k] = 1; k++; end
      else if (if_gnt) begin seq[k] = 0; k++; end
    end
    if_req = 0; dm_req = 0;
    chk("t3_grants_seen", 32'(k), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_order_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    repeat (4) step();

    // flush during WAIT
    if_req = 1; if_addr = 10'd6;
    step();
    chk("t5_if_gnt", if_gnt, 1);
    if_req = 0;
    step();
    if_flush = 1;
    step();
    if_flush = 0;
    chk("t5_no_rvalid", if_rvalid, 0);
    chk("t5_rdata_kept", if_rdata, 32'hDEADBEEF);
    step();
    if_req = 1; if_addr = 10'd6;
    step();
    chk("t5_regnt", if_gnt, 1);
    if_req = 0;
    step(); step();
    chk("t5_rvalid", if_rvalid, 1);
    chk("t5_rdata", if_rdata, 32'hA5000006);
    step();

    // reset during WAIT
    dm_req = 1; dm_we = 0; dm_addr = 10'd7;
    step();
    chk("t6_dm_gnt", dm_gnt, 1);
    dm_req = 0;
    step();
    rst_n = 0;
    #1;
    chk("t6_busy0", busy, 0);
    chk("t6_dm_rdata0", dm_rdata, 0);
    chk("t6_if_rdata0", if_rdata, 0);
    chk("t6_mem_addr0", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1;
    ok = 1;
    repeat (3) begin
      step();
      if (dm_rvalid || dm_wdone || if_rvalid) ok = 0;
    end
    chk("t6_no_pulse", 32'(ok), 1);
    if_req = 1; if_addr = 10'd5;
    step();
    chk("t6_gnt_from_idle", if_gnt, 1);
    if_req = 0;
    repeat (3) step();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      random_cycle();
      step();
    end
    idle_inputs();
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
